// File: rtl/yblock_cfg_loader.sv
// Clears one yblock, then shifts NWORDS column-wide words into its config chain, one confclk per word.
// 4 cycles per word (accept, setup, strobe, hold); in_ready only in WAIT; rd_valid has no backpressure.
module yblock_cfg_loader #(
    parameter int BLOCKWIDTH  = 8,
    parameter int BLOCKHEIGHT = 8,
    parameter int CELLBITS    = 2,
    parameter int CLEARCYC    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BLOCKWIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [BLOCKWIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  blkreset,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbitin,
    input  logic [BLOCKWIDTH-1:0] cbitout
);

    localparam int NWORDS = BLOCKHEIGHT * CELLBITS;
    localparam int CW     = $clog2(NWORDS + 1);
    localparam int TW     = (CLEARCYC > 1) ? $clog2(CLEARCYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TW-1:0]         r_timer;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_inc;
    logic                  w_accept;
    logic                  w_last;
    logic                  r_confclk;
    logic                  r_blkreset;
    logic                  r_rd_valid;
    logic [BLOCKWIDTH-1:0] r_rd_data;
    logic [BLOCKWIDTH-1:0] r_cbitin;

    assign w_accept    = (r_state == S_WAIT) && in_valid;
    assign w_count_inc = r_count + CW'(1);
    assign w_last      = (w_count_inc == CW'(NWORDS));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  if (r_timer == '0) w_next = S_WAIT;
            S_WAIT:   if (in_valid) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_HOLD;
            S_HOLD:   w_next = w_last ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // confclk/blkreset are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_count    <= '0;
            r_confclk  <= 1'b0;
            r_blkreset <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_cbitin   <= '0;
        end else begin
            r_state    <= w_next;
            r_confclk  <= (w_next == S_STROBE);
            r_blkreset <= (w_next == S_CLEAR);
            r_rd_valid <= (r_state == S_HOLD);
            if (r_state == S_IDLE && start) begin
                r_timer <= TW'(CLEARCYC - 1);
            end else if (r_state == S_CLEAR && r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end
            if (r_state == S_CLEAR) begin
                r_count <= '0;
            end else if (r_state == S_HOLD) begin
                r_count <= w_count_inc;
            end
            if (r_state == S_HOLD) begin
                r_rd_data <= cbitout;
            end
            if (w_accept) begin
                r_cbitin <= in_data;
            end
        end
    end

    assign in_ready = (r_state == S_WAIT);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign blkreset = r_blkreset;
    assign confclk  = r_confclk;
    assign cbitin   = r_cbitin;

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Directed bench for yblock_cfg_loader with a behavioural 16-deep column shift chain as the yblock.
// Inputs change and outputs are sampled 1 time unit after each rising clk edge.
module tb_yblock_cfg_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       blkreset;
    logic       confclk;
    logic [7:0] cbitin;
    logic [7:0] cbitout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    yblock_cfg_loader #(
        .BLOCKWIDTH (8),
        .BLOCKHEIGHT(8),
        .CELLBITS   (2),
        .CLEARCYC   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .blkreset(blkreset),
        .confclk (confclk),
        .cbitin  (cbitin),
        .cbitout (cbitout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // yblock stand-in: cbitout is the word pushed out of the deepest stage by the last confclk.
    logic [15:0][7:0] yb_chain = '0;
    logic [7:0]       yb_out   = '0;
    always @(posedge confclk) begin
        yb_out   <= yb_chain[15];
        yb_chain <= {yb_chain[14:0], cbitin};
    end
    assign cbitout = yb_out;

    int   cc_n = 0, cc_hi = 0, blk_hi = 0, done_n = 0, rv_n = 0, acc_n = 0, viol = 0;
    int   done_cyc = 0, blk_rise_cyc = 0;
    int   cc_cyc [64];
    int   rv_cyc [64];
    int   acc_cyc[64];
    logic [7:0] rd_log [64];
    logic [7:0] acc_log[64];
    logic cc_prev = 1'b0, blk_prev = 1'b0;

    always @(negedge clk) begin
        cc_prev  <= confclk;
        blk_prev <= blkreset;
        if (confclk === 1'b1) cc_hi <= cc_hi + 1;
        if (confclk === 1'b1 && cc_prev !== 1'b1) begin
            cc_cyc[cc_n % 64] <= cyc;
            cc_n <= cc_n + 1;
        end
        if (blkreset === 1'b1) blk_hi <= blk_hi + 1;
        if (blkreset === 1'b1 && blk_prev !== 1'b1) blk_rise_cyc <= cyc;
        if (done === 1'b1) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (rd_valid === 1'b1) begin
            rd_log[rv_n % 64] <= rd_data;
            rv_cyc[rv_n % 64] <= cyc;
            rv_n <= rv_n + 1;
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            acc_log[acc_n % 64] <= in_data;
            acc_cyc[acc_n % 64] <= cyc;
            acc_n <= acc_n + 1;
        end
        if ((confclk === 1'b1 && blkreset === 1'b1) ||
            (in_ready === 1'b1 && (confclk === 1'b1 || blkreset === 1'b1)))
            viol <= viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts a load at the current cycle t0, feeds base+0..base+15, returns at the cycle after done.
    task automatic run_load(input logic [7:0] base, input bit rnd_valid, input bit rnd_start,
                            input bit start_at_done, output int t0, output bit tmo);
        int idx;
        int budget;
        bit acc;
        tmo   = 1'b0;
        start = 1'b1;
        t0    = cyc;
        step(1);
        start  = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < 16 && budget < 600) begin
            in_data  = base + 8'(idx);
            in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd_start) start = ($urandom_range(0, 2) == 0);
            acc = in_valid && in_ready;
            step(1);
            start = 1'b0;
            budget++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        if (idx < 16) tmo = 1'b1;
        budget = 0;
        while (done !== 1'b1 && budget < 40) begin
            step(1);
            budget++;
        end
        if (done !== 1'b1) tmo = 1'b1;
        start = start_at_done;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int  t, p0, h0, b0, d0, r0, a0, bad, idx, budget;
        bit  tmo, acc;
        logic [7:0] orv;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset values
        step(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_confclk", confclk, 0);
        chk("rst_cbitin", cbitin, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_blkreset", blkreset, 1);

        // Idle after reset: blkreset drops one cycle after reset falls, no strobes
        reset = 1'b0;
        p0 = cc_n; b0 = blk_hi;
        step(10);
        chk("idle_blkreset", blkreset, 0);
        chk("idle_busy", busy, 0);
        chk("idle_confclk_pulses", cc_n - p0, 0);
        chk("idle_blkreset_cycles", blk_hi - b0, 1);

        // First load, continuous feed 0x01..0x10
        p0 = cc_n; h0 = cc_hi; b0 = blk_hi; d0 = done_n; r0 = rv_n; a0 = acc_n;
        run_load(8'h01, 1'b0, 1'b0, 1'b0, t, tmo);
        chk("l1_timeout", tmo, 0);
        chk("l1_pulses", cc_n - p0, 16);
        chk("l1_confclk_cycles", cc_hi - h0, 16);
        chk("l1_blkreset_cycles", blk_hi - b0, 4);
        chk("l1_blkreset_rise", blk_rise_cyc, t + 1);
        chk("l1_first_accept", acc_cyc[a0 % 64], t + 5);
        chk("l1_first_confclk", cc_cyc[p0 % 64], t + 7);
        chk("l1_first_rd_valid", rv_cyc[r0 % 64], t + 9);
        chk("l1_second_accept", acc_cyc[(a0 + 1) % 64], t + 9);
        chk("l1_done_count", done_n - d0, 1);
        chk("l1_done_cycle", done_cyc, t + 69);
        chk("l1_rd_count", rv_n - r0, 16);
        orv = 8'h00;
        for (int i = 0; i < 16; i++) orv = orv | rd_log[(r0 + i) % 64];
        chk("l1_readback_zero", orv, 0);
        chk("l1_cbitin_held", cbitin, 8'h10);
        chk("l1_idle_after", busy, 0);

        // Back-to-back second load reads back the first configuration
        r0 = rv_n; d0 = done_n;
        run_load(8'hA0, 1'b0, 1'b0, 1'b0, t, tmo);
        chk("l2_timeout", tmo, 0);
        chk("l2_done_count", done_n - d0, 1);
        chk("l2_done_cycle", done_cyc, t + 69);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("l2_readback_%0d", i), rd_log[(r0 + i) % 64], 8'(i + 1));
        end
        chk("l2_cbitin_held", cbitin, 8'hAF);

        // Randomly gapped in_valid: no lost or duplicated words
        p0 = cc_n; h0 = cc_hi; d0 = done_n; r0 = rv_n; a0 = acc_n;
        run_load(8'h30, 1'b1, 1'b0, 1'b0, t, tmo);
        chk("l3_timeout", tmo, 0);
        chk("l3_accepts", acc_n - a0, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (acc_log[(a0 + i) % 64] !== 8'h30 + 8'(i)) bad++;
        chk("l3_word_order", bad, 0);
        chk("l3_pulses", cc_n - p0, 16);
        chk("l3_confclk_cycles", cc_hi - h0, 16);
        chk("l3_done_count", done_n - d0, 1);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_log[(r0 + i) % 64] !== 8'hA0 + 8'(i)) bad++;
        chk("l3_readback", bad, 0);

        // Spurious start during the load and on the done cycle is ignored
        p0 = cc_n; b0 = blk_hi; d0 = done_n;
        run_load(8'h60, 1'b1, 1'b1, 1'b1, t, tmo);
        chk("l4_timeout", tmo, 0);
        chk("l4_blkreset_cycles", blk_hi - b0, 4);
        chk("l4_pulses", cc_n - p0, 16);
        chk("l4_busy_after_done", busy, 0);
        step(3);
        chk("l4_done_count", done_n - d0, 1);
        chk("l4_still_idle", busy, 0);

        // Reset after the 5th strobe aborts the load
        p0 = cc_n; d0 = done_n;
        start = 1'b1;
        step(1);
        start = 1'b0; in_valid = 1'b1; idx = 0; budget = 0;
        while ((cc_n - p0) < 5 && budget < 200) begin
            in_data = 8'h50 + 8'(idx);
            acc = in_ready;
            step(1);
            budget++;
            if (acc) idx++;
        end
        chk("ab_reached_5", cc_n - p0, 5);
        reset = 1'b1;
        step(1);
        chk("ab_confclk", confclk, 0);
        chk("ab_blkreset", blkreset, 1);
        chk("ab_busy", busy, 0);
        step(2);
        reset = 1'b0; in_valid = 1'b0;
        step(12);
        chk("ab_pulses", cc_n - p0, 5);
        chk("ab_no_done", done_n - d0, 0);
        chk("ab_blkreset_low", blkreset, 0);

        // Fresh load after the abort completes normally
        p0 = cc_n; d0 = done_n;
        run_load(8'hC0, 1'b0, 1'b0, 1'b0, t, tmo);
        chk("l5_timeout", tmo, 0);
        chk("l5_pulses", cc_n - p0, 16);
        chk("l5_done_count", done_n - d0, 1);
        chk("l5_done_cycle", done_cyc, t + 69);
        chk("no_overlap_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/yblock_cfg_loader.md
# yblock_cfg_loader

Sequencer that loads a configuration into one `yblock`. It clears the block, then streams column-wide configuration words into the `cbitin` bus, one `confclk` strobe per word. Bits shifted out of `cbitout` are returned as a readback stream. It sits between the host-side configuration port (wishbone glue or scan controller) and a single yblock instance.

## Interface
Parameters:
- `BLOCKWIDTH`, 8: columns of the target yblock; width of one configuration word.
- `BLOCKHEIGHT`, 8: rows of the target yblock.
- `CELLBITS`, 2: configuration bits per cell in the vertical shift chain.
- `CLEARCYC`, 4: cycles `blkreset` is held during the clear phase (≥1).

Ports:
- `clk`  in  1  single clock for all state.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_data`  in  BLOCKWIDTH  configuration word (bit x → column x).
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last strobe.
- `rd_data`  out  BLOCKWIDTH  `cbitout` captured after each strobe.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`; no backpressure.
- `blkreset`  out  1  drives yblock `reset`.
- `confclk`  out  1  drives yblock `confclk`.
- `cbitin`  out  BLOCKWIDTH  drives yblock `cbitin`.
- `cbitout`  in  BLOCKWIDTH  from yblock `cbitout`.

## Operation
- NWORDS = BLOCKHEIGHT*CELLBITS words per load. The counter is $clog2(NWORDS+1) bits wide and counts 0..NWORDS with no wrap.
- States: IDLE, CLEAR, WAIT, SETUP, STROBE, HOLD, DONE.
- IDLE: `start` → CLEAR and load the clear timer with CLEARCYC-1. `in_valid` is ignored.
- CLEAR: `blkreset`=1. When the timer reaches 0 → WAIT, with the word count set to 0.
- WAIT: `in_ready`=1. On `in_valid`&`in_ready`, register `in_data` into `cbitin` → SETUP. Otherwise stay in WAIT with no timeout.
- SETUP: `cbitin` stable and `confclk`=0 → STROBE.
- STROBE: `confclk`=1 for exactly one cycle → HOLD.
- HOLD:
  - `confclk`=0.
  - Capture `cbitout` into `rd_data` and pulse `rd_valid` in the following cycle.
  - Increment the count.
  - If the count becomes NWORDS → DONE, else → WAIT.
- DONE: `done`=1 for one cycle → IDLE.
- Shift order: the first word accepted ends in the deepest (bottom-row, last) position. The last word ends in the top row.
- `cbitin` holds its last value outside loads. It is not cleared at DONE.
- `start` while `busy`=1 is ignored and not queued.
- `confclk` and `blkreset` are registered outputs, glitch-free. `confclk`=1 and `blkreset`=1 are never asserted in the same cycle.

## Timing
- Reset values (in the cycle after `reset`=1 is sampled, and for as long as it stays high):
  - state IDLE;
  - `in_ready`, `busy`, `done`, `rd_valid`, `confclk` all 0;
  - `cbitin` 0 and `rd_data` 0;
  - `blkreset` = 1, held while `reset`=1, and deasserted the cycle after `reset` falls.
- Reset mid-load aborts immediately:
  - no further strobes and no `done`;
  - any partial configuration is cleared by the `blkreset` assertion.
- `start` at cycle t → `blkreset` high t+1..t+CLEARCYC → `in_ready` high at t+CLEARCYC+1.
- Per word, with `in_valid` held: accept cycle a, `confclk` high at a+2, `rd_valid` at a+4, next accept at a+4. That is 4 cycles per word at full rate.
- Full load with `in_valid` always high: `done` at t+CLEARCYC+1+4·NWORDS.
  - For 8×8, CELLBITS=2, CLEARCYC=4: `done` at t+69.
- `start` asserted in the same cycle that `done` is high is ignored. A new load needs `start` in IDLE.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values. `blkreset` is 1 only during reset. No `confclk` edges.
- 8×8 defaults, continuous feed of words 0x01..0x10 after `start` → exactly 16 `confclk` pulses, `done` at t+69, `blkreset` high exactly 4 cycles. `rd_data` for the first 16 words = 0x00 (block freshly cleared).
- Second load immediately after the first with words 0xA0..0xAF → the first 16 `rd_data` values equal the 0x01..0x10 sequence in order (readback of the previous configuration through the chain).
- `in_valid` toggled 1-0-0-1 randomly → `in_ready` only in WAIT. Words are never lost or duplicated. Strobe count = 16. `confclk` high exactly 1 cycle each.
- `start` pulsed during WAIT and HOLD → no restart, no extra `blkreset`, `done` once.
- `reset` asserted after the 5th strobe → `confclk` stays 0, `blkreset`=1, no `done`. A fresh `start` then completes a full 16-word load normally.
